// File: rtl/alu_exec_stage_pkg.sv
// rtl/alu_exec_stage_pkg.sv - alu_defs: opcodes, flag/condition types, exec payload, condition evaluator
package alu_defs;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;

    typedef struct packed {
        logic sign;
        logic zero;
        logic carryOut;
        logic overflow;
    } t_flag;

    typedef enum logic [3:0] {
        COND_AL  = 4'd0,
        COND_EQ  = 4'd1,
        COND_NE  = 4'd2,
        COND_MI  = 4'd3,
        COND_PL  = 4'd4,
        COND_VS  = 4'd5,
        COND_LT  = 4'd6,
        COND_GE  = 4'd7,
        COND_LTU = 4'd8,
        COND_GEU = 4'd9
    } t_cond;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [4:0]      rd;
        t_flag           flag;
        logic            condTrue;
    } t_exec;

    // Codes 10..15 are unassigned and evaluate false.
    function automatic logic cond_eval(input logic [3:0] c, input t_flag f);
        logic r;
        r = 1'b0;
        case (c)
            COND_AL:  r = 1'b1;
            COND_EQ:  r = f.zero;
            COND_NE:  r = ~f.zero;
            COND_MI:  r = f.sign;
            COND_PL:  r = ~f.sign;
            COND_VS:  r = f.overflow;
            COND_LT:  r = f.sign ^ f.overflow;
            COND_GE:  r = ~(f.sign ^ f.overflow);
            COND_LTU: r = f.carryOut;
            COND_GEU: r = ~f.carryOut;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_exec_stage_alu.sv
// rtl/alu_exec_stage_alu.sv - combinational ALU (ADD/SUB/AND/OR/XOR) with sign/zero/carry/overflow flags
module ALU
    import alu_defs::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] iX,
    input  logic [N-1:0] iY,
    input  logic [3:0]   iALUop,
    output logic [N-1:0] oResult,
    output t_flag        oFlag
);

    logic [N:0] wide;

    always_comb begin
        wide           = {1'b0, iX} + {1'b0, iY};
        oResult        = wide[N-1:0];
        oFlag          = '0;
        oFlag.carryOut = wide[N];
        oFlag.overflow = (iX[N-1] == iY[N-1]) && (wide[N-1] != iX[N-1]);
        case (iALUop)
            ALU_SUB: begin
                // N+1-bit difference: the top bit is the unsigned borrow
                wide           = {1'b0, iX} - {1'b0, iY};
                oResult        = wide[N-1:0];
                oFlag.carryOut = wide[N];
                oFlag.overflow = (iX[N-1] != iY[N-1]) && (wide[N-1] != iX[N-1]);
            end
            ALU_AND: begin
                oResult        = iX & iY;
                oFlag.carryOut = 1'b0;
                oFlag.overflow = 1'b0;
            end
            ALU_OR: begin
                oResult        = iX | iY;
                oFlag.carryOut = 1'b0;
                oFlag.overflow = 1'b0;
            end
            ALU_XOR: begin
                oResult        = iX ^ iY;
                oFlag.carryOut = 1'b0;
                oFlag.overflow = 1'b0;
            end
            default: ;
        endcase
        oFlag.zero = (oResult == '0);
        oFlag.sign = oResult[N-1];
    end

endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - registered ALU execute stage with valid/ready handshake; ALU_EXEC_SKID_EN adds a skid entry
module alu_exec_stage
    import alu_defs::*;
#(
    parameter int N = 32
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iValid,
    output logic         oReady,
    input  logic [N-1:0] iX,
    input  logic [N-1:0] iY,
    input  logic [3:0]   iALUop,
    input  logic [4:0]   iRd,
    input  logic         iSetFlags,
    input  logic [3:0]   iCond,
    output logic         oValid,
    input  logic         iReady,
    output logic [N-1:0] oResult,
    output logic [4:0]   oRd,
    output t_flag        oFlag,
    output logic         oCondTrue,
    output t_flag        oFlagReg
);

    logic [N-1:0] alu_res;
    t_flag        alu_flag;
    t_exec        new_exec;
    t_exec        out_q;
    logic         out_valid;
    t_flag        flag_reg;
    logic         accept;
    logic         xfer;

    ALU #(.N(N)) u_alu (
        .iX      (iX),
        .iY      (iY),
        .iALUop  (iALUop),
        .oResult (alu_res),
        .oFlag   (alu_flag)
    );

    always_comb begin
        new_exec          = '0;
        new_exec.result   = XLEN'(alu_res);
        new_exec.rd       = iRd;
        new_exec.flag     = alu_flag;
        new_exec.condTrue = cond_eval(iCond, alu_flag);
    end

    assign accept = iValid & oReady;
    assign xfer   = out_valid & iReady;

`ifdef ALU_EXEC_SKID_EN
    t_exec skid_q;
    logic  skid_valid;
    logic  ready_q;
    logic  skid_valid_nxt;

    // Ready is a flop so upstream never sees a path from downstream iReady.
    assign oReady         = ready_q;
    assign skid_valid_nxt = (xfer || !out_valid) ? 1'b0 : (skid_valid | accept);

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            out_q      <= '0;
            out_valid  <= 1'b0;
            skid_q     <= '0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            if (xfer || !out_valid) begin
                if (skid_valid) begin
                    out_q      <= skid_q;
                    out_valid  <= 1'b1;
                    skid_valid <= 1'b0;
                end else begin
                    out_valid <= accept;
                    if (accept) out_q <= new_exec;
                end
            end else if (accept) begin
                skid_q     <= new_exec;
                skid_valid <= 1'b1;
            end
            ready_q <= ~skid_valid_nxt;
        end
    end
`else
    assign oReady = ~iRst & (~out_valid | iReady);

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            out_q     <= '0;
            out_valid <= 1'b0;
        end else if (oReady) begin
            out_valid <= iValid;
            if (iValid) out_q <= new_exec;
        end
    end
`endif

    // Architectural flags commit at accept time, independent of downstream stalls.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            flag_reg <= '0;
        end else if (accept && iSetFlags) begin
            flag_reg <= alu_flag;
        end
    end

    assign oValid    = out_valid;
    assign oResult   = N'(out_q.result);
    assign oRd       = out_q.rd;
    assign oFlag     = out_q.flag;
    assign oCondTrue = out_q.condTrue;
    assign oFlagReg  = flag_reg;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - self-checking bench for alu_exec_stage (either ALU_EXEC_SKID_EN build)
module tb_alu_exec_stage;
    import alu_defs::*;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        iValid = 1'b0;
    logic        oReady;
    logic [31:0] iX = '0;
    logic [31:0] iY = '0;
    logic [3:0]  iALUop = '0;
    logic [4:0]  iRd = '0;
    logic        iSetFlags = 1'b0;
    logic [3:0]  iCond = '0;
    logic        oValid;
    logic        iReady = 1'b0;
    logic [31:0] oResult;
    logic [4:0]  oRd;
    t_flag       oFlag;
    logic        oCondTrue;
    t_flag       oFlagReg;

    int checks = 0;
    int errors = 0;

    t_exec       expq[$];
    t_flag       exp_flagreg = '0;
    logic        acc_last;
    logic        rec_en = 1'b0;
    logic [31:0] seq[$];

    always #5 iClk = ~iClk;

    alu_exec_stage #(.N(32)) dut (
        .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady),
        .iX(iX), .iY(iY), .iALUop(iALUop), .iRd(iRd), .iSetFlags(iSetFlags),
        .iCond(iCond), .oValid(oValid), .iReady(iReady), .oResult(oResult),
        .oRd(oRd), .oFlag(oFlag), .oCondTrue(oCondTrue), .oFlagReg(oFlagReg)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic t_exec model(input logic [31:0] x, input logic [31:0] y,
                                    input logic [3:0] op, input logic [4:0] rd, input logic [3:0] cond);
        t_exec       e;
        longint      sx;
        longint      sy;
        longint      sr;
        longint unsigned ux;
        longint unsigned uy;
        logic [31:0] r;
        t_flag       f;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'd0, x};
        uy = {32'd0, y};
        f  = '0;
        case (op)
            4'd1: begin
                r = x - y;
                f.carryOut = (x < y);
                sr = sx - sy;
                f.overflow = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = x ^ y;
            default: begin
                r = x + y;
                f.carryOut = (ux + uy) > 64'hFFFF_FFFF;
                sr = sx + sy;
                f.overflow = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
        endcase
        f.zero = (r == 32'd0);
        f.sign = r[31];
        e.result = r;
        e.rd = rd;
        e.flag = f;
        case (cond)
            4'd0: e.condTrue = 1'b1;
            4'd1: e.condTrue = f.zero;
            4'd2: e.condTrue = !f.zero;
            4'd3: e.condTrue = f.sign;
            4'd4: e.condTrue = !f.sign;
            4'd5: e.condTrue = f.overflow;
            4'd6: e.condTrue = f.sign != f.overflow;
            4'd7: e.condTrue = f.sign == f.overflow;
            4'd8: e.condTrue = f.carryOut;
            4'd9: e.condTrue = !f.carryOut;
            default: e.condTrue = 1'b0;
        endcase
        return e;
    endfunction

    // One clock: drive at negedge, check outputs, update the model for accept/transfer.
    task automatic cycle(input logic v, input logic [31:0] x, input logic [31:0] y, input logic [3:0] op,
                         input logic [4:0] rd, input logic sf, input logic [3:0] cond, input logic rdy);
        logic  r0;
        t_exec e;
        @(negedge iClk);
        iValid = v; iX = x; iY = y; iALUop = op; iRd = rd; iSetFlags = sf; iCond = cond; iReady = rdy;
        #1;
`ifdef ALU_EXEC_SKID_EN
        r0 = oReady;
        iReady = ~rdy;
        #1;
        chk("ready_indep_of_iready", oReady, r0);
        iReady = rdy;
        #1;
`else
        chk("ready_comb", oReady, !oValid || rdy);
`endif
        chk("flagreg", oFlagReg, exp_flagreg);
        chk("ovalid", oValid, expq.size() != 0);
        if (oValid && expq.size() != 0) begin
            chk("payload", {oResult, oRd, oFlag, oCondTrue},
                {expq[0].result, expq[0].rd, expq[0].flag, expq[0].condTrue});
            if (rdy) begin
                if (rec_en) seq.push_back(expq[0].result);
                void'(expq.pop_front());
            end
        end
        acc_last = v && oReady;
        if (acc_last) begin
            e = model(x, y, op, rd, cond);
            expq.push_back(e);
            if (sf) exp_flagreg = e.flag;
        end
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 32'd0, 32'd0, 4'd0, 5'd0, 1'b0, 4'd0, rdy);
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && expq.size() != 0; k++) idle(1'b1);
        chk("drained", expq.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ovalid"}, oValid, 0);
        chk({tag, "_ready"}, oReady, 0);
        chk({tag, "_outs"}, {oResult, oRd, oFlag, oCondTrue, oFlagReg}, 0);
    endtask

    task automatic pulse_reset();
        @(negedge iClk);
        iRst = 1'b1;
        iValid = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        @(negedge iClk);
        check_reset_outputs("rst_hold");
        iRst = 1'b0;
        expq.delete();
        exp_flagreg = '0;
    endtask

    initial begin
        int i;
        int guard;
        logic [1:0] pat[4];
        pat = '{2'b01, 2'b00, 2'b00, 2'b01};

        #1;
        check_reset_outputs("reset_state");
        @(negedge iClk);
        @(negedge iClk);
        iRst = 1'b0;
        idle(1'b1);

        // overflow into the sign bit
        cycle(1'b1, 32'h7FFF_FFFF, 32'd1, ALU_ADD, 5'd3, 1'b0, COND_AL, 1'b1);
        idle(1'b0);
        chk("add_result", oResult, 32'h8000_0000);
        chk("add_ovf_sign_carry", {oFlag.overflow, oFlag.sign, oFlag.carryOut}, 3'b110);
        drain();

        cycle(1'b1, 32'd5, 32'd5, ALU_SUB, 5'd4, 1'b1, COND_EQ, 1'b1);
        idle(1'b0);
        chk("sub_eq_result", oResult, 0);
        chk("sub_eq_flags", {oFlag.zero, oFlag.carryOut, oCondTrue}, 3'b101);
        chk("sub_eq_flagreg_zero", oFlagReg.zero, 1);
        drain();

        cycle(1'b1, 32'd3, 32'd7, ALU_SUB, 5'd5, 1'b0, COND_LTU, 1'b1);
        idle(1'b0);
        chk("sub_ltu", {oFlag.carryOut, oCondTrue}, 2'b11);
        drain();
        cycle(1'b1, 32'd3, 32'd7, ALU_SUB, 5'd6, 1'b1, COND_LT, 1'b1);
        idle(1'b0);
        chk("sub_lt", {oFlag.carryOut, oCondTrue}, 2'b11);
        drain();
        cycle(1'b1, 32'h8000_0000, 32'd1, ALU_SUB, 5'd7, 1'b0, COND_LT, 1'b1);
        idle(1'b0);
        chk("sub_min_flags", {oFlag.overflow, oFlag.sign}, 2'b10);
        drain();

        // non-flag-setting op leaves the 3-7 flags in place
        cycle(1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_AND, 5'd8, 1'b0, COND_AL, 1'b1);
        idle(1'b1);
        chk("and_flagreg_kept", {oFlagReg.sign, oFlagReg.carryOut, oFlagReg.zero}, 3'b110);
        drain();

        // back-to-back with stalls; ordering and values recorded
        rec_en = 1'b1;
        seq.delete();
        i = 1;
        guard = 0;
        while (i <= 8 && guard < 100) begin
            cycle(1'b1, i, i, ALU_ADD, 5'(i), 1'b0, COND_AL, pat[guard % 4][0]);
            if (acc_last) i++;
            guard++;
        end
        drain();
        rec_en = 1'b0;
        chk("burst_count", seq.size(), 8);
        for (int k = 0; k < 8 && k < seq.size(); k++) chk("burst_value", seq[k], 2 * (k + 1));

        for (int k = 0; k < 400; k++) begin
            logic [31:0] x;
            logic [31:0] y;
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
            if ($urandom_range(0, 7) == 0) y = x;
            cycle($urandom_range(0, 3) != 0, x, y, 4'($urandom_range(0, 15)), 5'($urandom),
                  1'($urandom), 4'($urandom_range(0, 15)), $urandom_range(0, 2) != 0);
        end
        drain();

        // fill output (and skid entry when present), then reset mid-flight
        for (int k = 0; k < 3; k++)
            cycle(1'b1, 32'd10 + k, 32'd1, ALU_SUB, 5'd9, 1'b1, COND_NE, 1'b0);
        pulse_reset();
        idle(1'b1);
        idle(1'b1);
        chk("post_reset_idle", oValid, 0);
        cycle(1'b1, 32'd1, 32'd2, ALU_XOR, 5'd1, 1'b1, COND_PL, 1'b1);
        idle(1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 Parameter: N, 32, operand/result width in bits.
REQ-002 iClk  input  1  sole clock; all state updates on its rising edge.
REQ-003 iRst  input  1  asynchronous, active-high reset.
REQ-004 iValid  input  1  upstream presents an operation.
REQ-005 oReady  output  1  stage accepts an operation this cycle.
REQ-006 iX, iY  input  N each  operands.
REQ-007 iALUop  input  4  alu_defs opcode (ADD, SUB, AND, OR, XOR).
REQ-008 iRd  input  5  destination register tag, carried unchanged.
REQ-009 iSetFlags  input  1  operation updates the architectural flag register.
REQ-010 iCond  input  4  alu_defs::t_cond, evaluated on this operation's flags.
REQ-011 oValid  output  1  result held for downstream.
REQ-012 iReady  input  1  downstream accepts the result.
REQ-013 oResult  output  N  registered ALU result.
REQ-014 oRd  output  5  tag of oResult.
REQ-015 oFlag  output  alu_defs::t_flag  registered flags of this operation.
REQ-016 oCondTrue  output  1  registered condition outcome.
REQ-017 oFlagReg  output  alu_defs::t_flag  architectural flag register.

Function
REQ-018 Accept = iValid & oReady; result = ALU(iX, iY, iALUop), computed combinationally in the accept cycle.
REQ-019 Latency: an operation accepted in cycle t is presented with oValid=1 in cycle t+1.
REQ-020 Transfer = oValid & iReady; oResult/oRd/oFlag/oCondTrue stay stable while oValid=1 and iReady=0.
REQ-021 No operation is dropped or duplicated; output order equals accept order.
REQ-022 Accept and transfer in the same cycle: the new operation replaces the departing one; oValid stays 1.
REQ-023 oFlagReg loads the accepted operation's flags on accept when iSetFlags=1, otherwise holds; load occurs at accept, not at transfer.
REQ-024 t_cond codes: AL=1; EQ=zero; NE=~zero; MI=sign; PL=~sign; VS=overflow; LT=sign^overflow; GE=~(sign^overflow); LTU=carryOut; GEU=~carryOut; undefined codes evaluate to 0.
REQ-025 carryOut follows ALU semantics: ADD carry-out; SUB borrow (1 when iX<iY unsigned).
REQ-026 iALUop values outside the defined set execute as ADD.

Reset
REQ-027 While iRst=1: oValid=0, oResult=0, oRd=0, oFlag=0, oCondTrue=0, oFlagReg=0, skid entry empty.
REQ-028 Reset asserted mid-operation discards all held operations; no transfer completes in the reset-release cycle unless a new accept preceded it.
REQ-029 oReady=0 while iRst=1.

Configuration
REQ-030 Macro ALU_EXEC_SKID_EN defined: a second (skid) entry exists; oReady = skid empty, a registered signal with no combinational path from iReady; an accept while output is full and not transferring lands in the skid entry; skid entry moves to output on the next transfer.
REQ-031 Macro ALU_EXEC_SKID_EN undefined: single output entry; oReady = ~oValid | iReady (combinational from iReady).
REQ-032 Both builds produce identical output sequences for identical accepted-operation streams.

Structure
REQ-033 t_cond enum and an exec payload struct (result, rd, flag, condTrue) shall be added to package alu_defs beside t_flag and opcodes.
REQ-034 The existing combinational ALU shall be instantiated as the single sub-module (ALU, N passed through); no arithmetic is duplicated in this block.

Verification
REQ-035 ADD 0x7FFFFFFF+1, iReady=1 -> next cycle oResult=0x80000000, overflow=1, sign=1, carryOut=0.
REQ-036 SUB 5-5, iSetFlags=1, iCond=EQ -> oResult=0, zero=1, carryOut=0, oCondTrue=1; oFlagReg.zero=1 one cycle after accept.
REQ-037 SUB 3-7, iCond=LTU then iCond=LT -> carryOut=1, oCondTrue=1 both; SUB 0x80000000-1, iCond=LT -> oCondTrue=0 (overflow=1, sign=0).
REQ-038 Back-to-back ops 1..8 (ADD i+i), iReady toggled 1,0,0,1 pattern -> outputs 2,4,..,16 in order, no loss/duplication, outputs stable while stalled; SKID build: oReady never depends on same-cycle iReady.
REQ-039 AND with iSetFlags=0 after a flag-setting SUB -> oFlagReg unchanged.
REQ-040 iRst pulsed while oValid=1 (and skid full in SKID build) -> all outputs 0 immediately, oValid=0 after release until a new accept.
